pll_lock_sequencer: RTL and testbench

- Sequences the audio-clock PLL (12.5 MHz reference to 12.288 MHz microphone/audio clock) from power-up through lock.
- Pulses the PLL reset, waits for lock, and qualifies lock stability before releasing the downstream audio-domain reset.
- Detects loss of lock, retries, and reports a fault after repeated lock timeouts.
- Runs on the free-running reference clock and sits beside the PLL wrapper in the array top level.

---
 rtl/pll_lock_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings the audio-clock PLL out of reset, waits for lock, qualifies that
//   lock as stable and only then releases the audio-domain reset. A lock loss
//   in RUN restarts the sequence. Repeated lock timeouts end in FAULT, which
//   is left only through i_soft_reset_req or i_reset_n.
//
// Ports
//   i_clk              reference clock (same clock as the PLL refclk)
//   i_reset_n          asynchronous active-low reset
//   i_pll_locked       PLL lock flag, asynchronous, synchronized internally
//   i_soft_reset_req   single-cycle request to restart the sequence
//   o_pll_rst          PLL reset, active high
//   o_clk_ready        audio clock valid
//   o_audio_reset_n    active-low reset request to the audio domain
//   o_fault            retries exhausted
//   o_retry_count      failed lock attempts since the last RUN or soft reset
//   o_lock_loss_count  RUN-to-lock-loss events, saturating at 255
//   o_state            RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 125,
  parameter int LOCK_STABLE_CYCLES  = 1250,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_WIDTH           = 17
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_pll_locked,
  input  logic       i_soft_reset_req,
  output logic       o_pll_rst,
  output logic       o_clk_ready,
  output logic       o_audio_reset_n,
  output logic       o_fault,
  output logic [1:0] o_retry_count,
  output logic [7:0] o_lock_loss_count,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  // Terminal timer values: each phase ends on the cycle its count reaches N-1.
  localparam logic [CNT_WIDTH-1:0] L_RST_LAST     = CNT_WIDTH'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] L_STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] L_TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] L_TIMER_ONE    = CNT_WIDTH'(1);
  localparam logic [1:0]           L_MAX_RETRIES  = 2'(MAX_RETRIES);

  state_e               r_state;
  state_e               w_next_state;
  logic [CNT_WIDTH-1:0] r_timer;
  logic [CNT_WIDTH-1:0] w_next_timer;
  logic [1:0]           r_retry;
  logic [1:0]           w_next_retry;
  logic [7:0]           r_lock_loss;
  logic [7:0]           w_next_lock_loss;
  logic                 r_lk_meta;
  logic                 r_lk_sync;
  logic                 w_lk;
  logic                 r_pll_rst;
  logic                 r_clk_ready;
  logic                 r_audio_reset_n;
  logic                 r_fault;

  assign w_lk = r_lk_sync;

  // Two-flop synchronizer for the asynchronous PLL lock flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lk_meta <= 1'b0;
      r_lk_sync <= 1'b0;
    end else begin
      r_lk_meta <= i_pll_locked;
      r_lk_sync <= r_lk_meta;
    end
  end

  // Next-state, shared timer, retry and lock-loss bookkeeping.
  always_comb begin
    w_next_state     = r_state;
    w_next_timer     = r_timer;
    w_next_retry     = r_retry;
    w_next_lock_loss = r_lock_loss;
    if (i_soft_reset_req) begin
      // Soft reset outranks everything, including a same-cycle lock loss.
      w_next_state = S_RESET_PLL;
      w_next_timer = '0;
      w_next_retry = 2'd0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_timer == L_RST_LAST) begin
            w_next_state = S_WAIT_LOCK;
            w_next_timer = '0;
          end else begin
            w_next_timer = r_timer + L_TIMER_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (w_lk) begin
            w_next_state = S_STABLE;
            w_next_timer = '0;
          end else if (r_timer == L_TIMEOUT_LAST) begin
            w_next_timer = '0;
            if (r_retry < L_MAX_RETRIES) begin
              w_next_retry = r_retry + 2'd1;
              w_next_state = S_RESET_PLL;
            end else begin
              w_next_state = S_FAULT;
            end
          end else begin
            w_next_timer = r_timer + L_TIMER_ONE;
          end
        end
        S_STABLE: begin
          if (!w_lk) begin
            // A glitch only restarts qualification; it is not a failed attempt.
            w_next_state = S_WAIT_LOCK;
            w_next_timer = '0;
          end else if (r_timer == L_STABLE_LAST) begin
            w_next_state = S_RUN;
            w_next_timer = '0;
            w_next_retry = 2'd0;
          end else begin
            w_next_timer = r_timer + L_TIMER_ONE;
          end
        end
        S_RUN: begin
          if (!w_lk) begin
            w_next_state = S_RESET_PLL;
            w_next_timer = '0;
            if (r_lock_loss != 8'hFF) begin
              w_next_lock_loss = r_lock_loss + 8'd1;
            end else begin
              w_next_lock_loss = r_lock_loss;
            end
          end else begin
            w_next_retry = 2'd0;
          end
        end
        S_FAULT: begin
          w_next_state = S_FAULT;
        end
        default: begin
          w_next_state = S_RESET_PLL;
          w_next_timer = '0;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they change on the same edge as o_state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state         <= S_RESET_PLL;
      r_timer         <= '0;
      r_retry         <= 2'd0;
      r_lock_loss     <= 8'd0;
      r_pll_rst       <= 1'b1;
      r_clk_ready     <= 1'b0;
      r_audio_reset_n <= 1'b0;
      r_fault         <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_timer         <= w_next_timer;
      r_retry         <= w_next_retry;
      r_lock_loss     <= w_next_lock_loss;
      r_pll_rst       <= (w_next_state == S_RESET_PLL) || (w_next_state == S_FAULT);
      r_clk_ready     <= (w_next_state == S_RUN);
      r_audio_reset_n <= (w_next_state == S_RUN);
      r_fault         <= (w_next_state == S_FAULT);
    end
  end

  assign o_state           = r_state;
  assign o_pll_rst         = r_pll_rst;
  assign o_clk_ready       = r_clk_ready;
  assign o_audio_reset_n   = r_audio_reset_n;
  assign o_fault           = r_fault;
  assign o_retry_count     = r_retry;
  assign o_lock_loss_count = r_lock_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//   Directed bench for pll_lock_sequencer with short cycle parameters
//   (reset pulse 4, stable 8, timeout 20, two retries). Inputs change 1 ns
//   after a rising edge; outputs are sampled at that same point.
module tb_pll_lock_sequencer;

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       clk_ready;
  logic       audio_reset_n;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_llc  = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(20),
    .MAX_RETRIES        (2),
    .CNT_WIDTH          (17)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_pll_locked     (pll_locked),
    .i_soft_reset_req (soft_reset_req),
    .o_pll_rst        (pll_rst),
    .o_clk_ready      (clk_ready),
    .o_audio_reset_n  (audio_reset_n),
    .o_fault          (fault),
    .o_retry_count    (retry_count),
    .o_lock_loss_count(lock_loss_count),
    .o_state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
    int n;
    n = 0;
    while (state !== s && n < bound) begin
      step(1);
      n++;
    end
    check_eq(tag, {29'd0, state}, {29'd0, s});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, {29'd0, state}, {29'd0, S_RESET_PLL});
    check_eq({tag, "_pll_rst"}, {31'd0, pll_rst}, 32'd1);
    check_eq({tag, "_clk_ready"}, {31'd0, clk_ready}, 32'd0);
    check_eq({tag, "_audio_reset_n"}, {31'd0, audio_reset_n}, 32'd0);
    check_eq({tag, "_fault"}, {31'd0, fault}, 32'd0);
    check_eq({tag, "_retry"}, {30'd0, retry_count}, 32'd0);
    check_eq({tag, "_llc"}, {24'd0, lock_loss_count}, 32'd0);
  endtask

  // Bound on total simulated time in case a wait logic error slips through.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset_n        = 1'b0;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    step(3);
    check_reset_outputs("reset");

    // Normal bring-up: reset pulse length, sync latency, stable qualification.
    reset_n = 1'b1;
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 20) begin
      step(1);
      cnt++;
    end
    check_eq("rst_pulse_len", cnt, 32'd4);
    check_eq("bringup_wait", {29'd0, state}, {29'd0, S_WAIT_LOCK});
    step(3);
    pll_locked = 1'b1;
    step(2);
    check_eq("sync_latency_wait", {29'd0, state}, {29'd0, S_WAIT_LOCK});
    step(1);
    check_eq("stable_entry", {29'd0, state}, {29'd0, S_STABLE});
    step(7);
    check_eq("stable_7", {29'd0, state}, {29'd0, S_STABLE});
    check_eq("stable_7_clk_ready", {31'd0, clk_ready}, 32'd0);
    step(1);
    check_eq("run_state", {29'd0, state}, {29'd0, S_RUN});
    check_eq("run_clk_ready", {31'd0, clk_ready}, 32'd1);
    check_eq("run_audio_reset_n", {31'd0, audio_reset_n}, 32'd1);
    check_eq("run_pll_rst", {31'd0, pll_rst}, 32'd0);
    check_eq("run_retry", {30'd0, retry_count}, 32'd0);

    // Lock loss in RUN: visible after two sync cycles plus one register.
    pll_locked = 1'b0;
    step(2);
    check_eq("loss_still_run", {29'd0, state}, {29'd0, S_RUN});
    check_eq("loss_still_ready", {31'd0, clk_ready}, 32'd1);
    step(1);
    exp_llc = 1;
    check_eq("loss_state", {29'd0, state}, {29'd0, S_RESET_PLL});
    check_eq("loss_clk_ready", {31'd0, clk_ready}, 32'd0);
    check_eq("loss_audio_reset_n", {31'd0, audio_reset_n}, 32'd0);
    check_eq("loss_llc", {24'd0, lock_loss_count}, exp_llc);

    // Relock with a one-cycle glitch during STABLE.
    pll_locked = 1'b1;
    step(4);
    check_eq("relock_wait", {29'd0, state}, {29'd0, S_WAIT_LOCK});
    step(1);
    check_eq("relock_stable", {29'd0, state}, {29'd0, S_STABLE});
    step(4);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    check_eq("glitch_not_seen", {29'd0, state}, {29'd0, S_STABLE});
    step(1);
    check_eq("glitch_wait", {29'd0, state}, {29'd0, S_WAIT_LOCK});
    check_eq("glitch_retry", {30'd0, retry_count}, 32'd0);
    step(1);
    check_eq("glitch_restable", {29'd0, state}, {29'd0, S_STABLE});
    step(7);
    check_eq("glitch_stable_7", {29'd0, state}, {29'd0, S_STABLE});
    step(1);
    check_eq("glitch_run", {29'd0, state}, {29'd0, S_RUN});

    // Soft reset arriving in the same cycle the FSM sees lk fall.
    pll_locked = 1'b0;
    step(2);
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    check_eq("simul_state", {29'd0, state}, {29'd0, S_RESET_PLL});
    check_eq("simul_llc", {24'd0, lock_loss_count}, exp_llc);
    check_eq("simul_clk_ready", {31'd0, clk_ready}, 32'd0);
    pll_locked = 1'b1;
    wait_state(S_RUN, 40, "simul_relock");

    // Timeouts and fault: soft reset from RUN while lock is already gone.
    pll_locked = 1'b0;
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    check_eq("to_start_state", {29'd0, state}, {29'd0, S_RESET_PLL});
    step(23);
    check_eq("to1_wait", {29'd0, state}, {29'd0, S_WAIT_LOCK});
    step(1);
    check_eq("to1_state", {29'd0, state}, {29'd0, S_RESET_PLL});
    check_eq("to1_retry", {30'd0, retry_count}, 32'd1);
    step(24);
    check_eq("to2_state", {29'd0, state}, {29'd0, S_RESET_PLL});
    check_eq("to2_retry", {30'd0, retry_count}, 32'd2);
    step(24);
    check_eq("fault_state", {29'd0, state}, {29'd0, S_FAULT});
    check_eq("fault_flag", {31'd0, fault}, 32'd1);
    check_eq("fault_pll_rst", {31'd0, pll_rst}, 32'd1);
    check_eq("fault_clk_ready", {31'd0, clk_ready}, 32'd0);
    step(5);
    check_eq("fault_sticky", {29'd0, state}, {29'd0, S_FAULT});
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    check_eq("fault_clear_state", {29'd0, state}, {29'd0, S_RESET_PLL});
    check_eq("fault_clear_flag", {31'd0, fault}, 32'd0);
    check_eq("fault_clear_retry", {30'd0, retry_count}, 32'd0);
    check_eq("fault_clear_llc", {24'd0, lock_loss_count}, exp_llc);
    cnt = 1;
    while (pll_rst === 1'b1 && cnt < 20) begin
      step(1);
      cnt++;
    end
    check_eq("soft_rst_pulse_len", cnt, 32'd5);

    // Repeated lock losses: counter saturates at 255.
    pll_locked = 1'b1;
    wait_state(S_RUN, 40, "sat_first_run");
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b0;
      wait_state(S_RESET_PLL, 10, "sat_loss");
      if (exp_llc < 255) exp_llc++;
      check_eq("sat_llc", {24'd0, lock_loss_count}, exp_llc);
      pll_locked = 1'b1;
      wait_state(S_RUN, 40, "sat_relock");
    end
    check_eq("sat_final", {24'd0, lock_loss_count}, 32'd255);

    // Asynchronous reset in the middle of STABLE, checked between edges.
    pll_locked = 1'b0;
    wait_state(S_RESET_PLL, 10, "areset_loss");
    pll_locked = 1'b1;
    wait_state(S_STABLE, 20, "areset_stable");
    step(2);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    step(2);
    reset_n = 1'b1;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
